occupancy_fsm: RTL

- Parametrised successor to the single-event entry/exit FSM.
- Decodes direction of passage through a two-beam doorway: SW[1] is the outer beam, SW[0] is the inner beam.
- Keeps a saturating occupancy count with capacity, full and abort handling, and shows the last event on HEX0.
- Sits between the board switches/sensors and the LED/7-segment outputs of the access-control demo.

---
 rtl/occupancy_fsm.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/occupancy_fsm.sv
// Two-beam doorway direction decoder with saturating occupancy count.
// Outer beam is SW[1], inner beam is SW[0]; HEX0 shows the last event.
module occupancy_fsm #(
    parameter int CNT_W       = 8,
    parameter int MAX_OCC     = 50,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       SW,
    output logic [6:0]       HEX0,
    output logic [CNT_W-1:0] COUNT,
    output logic             LEDG,
    output logic             LEDR,
    output logic             EVT_OUT,
    output logic             REJECT,
    output logic             ABORT
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(MAX_OCC);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3,
        WAIT_CLR
    } state_t;

    state_t state;
    state_t state_n;

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]       s;
    logic [1:0]       s_prev;
    logic             changed;
    logic             active;
    logic             timed_out;
    logic [TW-1:0]    tmr;
    logic [TW-1:0]    tmr_n;

    logic             ent_evt;
    logic             ext_evt;
    logic             abt_evt;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count_n;
    logic [6:0]       hex_n;
    logic             ledg_n;
    logic             evt_n;
    logic             rej_n;

    assign s       = sync_q[SYNC_STAGES-1];
    assign changed = (s != s_prev);
    assign active  = (state != IDLE) && (state != WAIT_CLR);
    assign full    = (COUNT == CAP);
    assign empty   = (COUNT == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Passage sequencer: forward walk through the beams, silent back-outs,
    // and any skipped beam pattern treated as an illegal sequence.
    always_comb begin
        state_n = state;
        ent_evt = 1'b0;
        ext_evt = 1'b0;
        abt_evt = 1'b0;
        unique case (state)
            IDLE: begin
                case (s)
                    2'b10: state_n = E1;
                    2'b01: state_n = X1;
                    2'b11: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            E1: begin
                case (s)
                    2'b11: state_n = E2;
                    2'b00: state_n = IDLE;
                    2'b01: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            E2: begin
                case (s)
                    2'b01: state_n = E3;
                    2'b10: state_n = E1;
                    2'b00: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            E3: begin
                case (s)
                    2'b00: begin
                        state_n = IDLE;
                        ent_evt = 1'b1;
                    end
                    2'b11: state_n = E2;
                    2'b10: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            X1: begin
                case (s)
                    2'b11: state_n = X2;
                    2'b00: state_n = IDLE;
                    2'b10: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            X2: begin
                case (s)
                    2'b10: state_n = X3;
                    2'b01: state_n = X1;
                    2'b00: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            X3: begin
                case (s)
                    2'b00: begin
                        state_n = IDLE;
                        ext_evt = 1'b1;
                    end
                    2'b11: state_n = X2;
                    2'b01: begin
                        state_n = WAIT_CLR;
                        abt_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
            WAIT_CLR: begin
                if (s == 2'b00) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A sensor change in this cycle always takes priority over the timeout.
        timed_out = active && !changed && (tmr == T_LAST);
        if (timed_out) begin
            state_n = (s == 2'b00) ? IDLE : WAIT_CLR;
            ent_evt = 1'b0;
            ext_evt = 1'b0;
            abt_evt = 1'b1;
        end

        if (!active || changed || timed_out) begin
            tmr_n = '0;
        end else begin
            tmr_n = tmr + 1'b1;
        end
    end

    always_comb begin
        count_n = COUNT;
        hex_n   = HEX0;
        ledg_n  = 1'b0;
        evt_n   = 1'b0;
        rej_n   = 1'b0;
        if (ent_evt) begin
            if (full) begin
                rej_n = 1'b1;
                hex_n = GLYPH_F;
            end else begin
                count_n = COUNT + 1'b1;
                ledg_n  = 1'b1;
                hex_n   = GLYPH_E;
            end
        end
        if (ext_evt) begin
            if (empty) begin
                rej_n = 1'b1;
                hex_n = GLYPH_F;
            end else begin
                count_n = COUNT - 1'b1;
                evt_n   = 1'b1;
                hex_n   = GLYPH_S;
            end
        end
        if (abt_evt) begin
            hex_n = GLYPH_DASH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            s_prev  <= 2'b00;
            tmr     <= '0;
            COUNT   <= '0;
            HEX0    <= GLYPH_BLANK;
            LEDG    <= 1'b0;
            LEDR    <= 1'b0;
            EVT_OUT <= 1'b0;
            REJECT  <= 1'b0;
            ABORT   <= 1'b0;
        end else begin
            state   <= state_n;
            s_prev  <= s;
            tmr     <= tmr_n;
            COUNT   <= count_n;
            HEX0    <= hex_n;
            LEDG    <= ledg_n;
            LEDR    <= (count_n == CAP);
            EVT_OUT <= evt_n;
            REJECT  <= rej_n;
            ABORT   <= abt_evt;
        end
    end

endmodule
